ember_inst_decoder: RTL and testbench
=====================================

Name: ember_inst_decoder

Overview:
- Per-thread instruction decoder for the Ember core.
- Captures a 32-bit instruction word and splits it into opcode, mode, register and flag fields.
- Collects up to three 64-bit extension words (immediate, displacement, extension) from the L1-D data path.
- Signals the thread FSM when decoding is finished and whether the result is valid.

Parameters:
DATA_W, 64, width of extension words and imm/disp/ext outputs
INST_W, 32, instruction word width (fixed layout; only 32 supported)

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
inst_load  input  1  one-cycle strobe: capture inst and start a new decode
inst  input  INST_W  instruction word
data_load  input  1  one-cycle strobe: data holds the next extension word
data  input  DATA_W  extension word
opcode  output  12  inst[31:20]
mode  output  4  inst[19:16]
rsrc  output  6  inst[15:10]
rdest  output  6  inst[9:4]
flags  output  4  inst[3:0]; bit0 = instruction-valid
imm  output  DATA_W  immediate word
disp  output  DATA_W  displacement word
ext  output  DATA_W  extension word
imm_present  output  1  flags[1] of captured instruction
disp_present  output  1  flags[2]
ext_present  output  1  flags[3]
finished_decoding  output  1  all required words received
decoded_valid  output  1  finished and instruction legal

Behaviour:
- Reset: all outputs 0; FSM in IDLE.
- FSM states:
  - IDLE
  - WAIT_IMM
  - WAIT_DISP
  - WAIT_EXT
  - DONE
- inst_load at edge N:
  - Fields, present bits and next state are registered at N; visible in cycle N+1.
  - imm, disp and ext are cleared to 0.
  - finished_decoding drops to 0, unless no extension is required.
- Next state after capture: first required wait state in the fixed order imm, disp, ext. If none is required, go to DONE.
- No extensions: finished_decoding = 1 in cycle N+1, i.e. one-cycle latency.
- data_load in a WAIT state:
  - data is stored to that state's field.
  - FSM advances to the next required wait state, else to DONE.
  - Output visible next cycle.
- Entering DONE sets finished_decoding = 1. It holds until the next inst_load or reset.
- data_load in IDLE or DONE: ignored; no field changes.
- inst_load together with data_load: inst_load wins. The data word is discarded and the new decode starts.
- inst_load mid-decode: aborts the current decode and restarts. The partial imm, disp and ext words are cleared.
- decoded_valid = finished_decoding & flags[0] & (rsrc < 40) & (rdest < 40), plus the strict checks when enabled. Registered together with finished_decoding.
- imm, disp and ext are stored raw, full DATA_W bits; no sign extension.
- Outputs are stable while no strobe is asserted.

Optional Feature:
- Macro: STRICT_MODE_CHECK_EN.
- Defined: decoded_valid additionally requires:
  - mode in 1..4;
  - mode 3 implies imm_present;
  - mode 4 implies disp_present.
- Undefined: mode is not checked; decoded_valid uses only flags[0] and the register range checks.

Test Plan:
1. Reset, then inst_load with inst = 0x11521051 -> next cycle:
   - fields: opcode = 0x115, mode = 2, rsrc = 4, rdest = 5, flags = 1;
   - status: finished_decoding = 1, decoded_valid = 1, imm = 0.
2. inst_load with inst = 0x11531053 (imm required) -> finished_decoding = 0. Then data_load with data = 0xDEADBEEF_CAFEF00D -> next cycle: imm = that value, finished_decoding = 1, decoded_valid = 1.
3. inst_load with flags = 0xF -> three data_load strobes with 1, 2, 3 -> result imm = 1, disp = 2, ext = 3. finished_decoding rises only after the third strobe.
4. inst_load with rsrc = 45, flags = 1 -> finished_decoding = 1, decoded_valid = 0. Separately, flags = 0 -> decoded_valid = 0.
5. inst_load with flags = 3, then a second inst_load (flags = 1) before any data_load -> finished_decoding = 1 the cycle after the second load; imm = 0. A subsequent data_load leaves imm = 0.
6. With STRICT_MODE_CHECK_EN defined: inst with mode = 0 or mode = 3 without imm -> decoded_valid = 0. Without the macro the same inst -> decoded_valid = 1.

Source files
------------

// File: rtl/ember_inst_decoder.sv
// ember_inst_decoder: captures an instruction, collects its imm/disp/ext words and flags completion.
// Define STRICT_MODE_CHECK_EN to add mode legality checks to decoded_valid.
module ember_inst_decoder #(
    parameter int DATA_W = 64,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_load,
    input  logic [INST_W-1:0] inst,
    input  logic              data_load,
    input  logic [DATA_W-1:0] data,
    output logic [11:0]       opcode,
    output logic [3:0]        mode,
    output logic [5:0]        rsrc,
    output logic [5:0]        rdest,
    output logic [3:0]        flags,
    output logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] disp,
    output logic [DATA_W-1:0] ext,
    output logic              imm_present,
    output logic              disp_present,
    output logic              ext_present,
    output logic              finished_decoding,
    output logic              decoded_valid
);
    typedef enum logic [2:0] {IDLE, WAIT_IMM, WAIT_DISP, WAIT_EXT, DONE} state_t;

    state_t state, nxt;
    logic [3:0] nf;
    logic [5:0] nsrc, ndst;
    logic ok, in_wait, first_done;

    function automatic state_t pick(input logic [2:0] req);
        pick = req[0] ? WAIT_IMM : req[1] ? WAIT_DISP : req[2] ? WAIT_EXT : DONE;
    endfunction

    assign imm_present  = flags[1];
    assign disp_present = flags[2];
    assign ext_present  = flags[3];

    // Legality is judged on the fields that will be held once this edge completes
    assign nf   = inst_load ? inst[3:0] : flags;
    assign nsrc = inst_load ? inst[15:10] : rsrc;
    assign ndst = inst_load ? inst[9:4] : rdest;

`ifdef STRICT_MODE_CHECK_EN
    logic [3:0] nm;
    assign nm = inst_load ? inst[19:16] : mode;
    assign ok = nf[0] && nsrc < 6'd40 && ndst < 6'd40 && nm >= 4'd1 && nm <= 4'd4
                && (nm != 4'd3 || nf[1]) && (nm != 4'd4 || nf[2]);
`else
    assign ok = nf[0] && nsrc < 6'd40 && ndst < 6'd40;
`endif

    assign in_wait    = state inside {WAIT_IMM, WAIT_DISP, WAIT_EXT};
    assign first_done = inst[3:1] == 3'b000;
    assign nxt = state == WAIT_IMM ? pick({flags[3:2], 1'b0}) :
                 state == WAIT_DISP ? pick({flags[3], 2'b00}) : DONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            opcode            <= '0;
            mode              <= '0;
            rsrc              <= '0;
            rdest             <= '0;
            flags             <= '0;
            imm               <= '0;
            disp              <= '0;
            ext               <= '0;
            finished_decoding <= 1'b0;
            decoded_valid     <= 1'b0;
        end else if (inst_load) begin
            opcode            <= inst[31:20];
            mode              <= inst[19:16];
            rsrc              <= inst[15:10];
            rdest             <= inst[9:4];
            flags             <= inst[3:0];
            imm               <= '0;
            disp              <= '0;
            ext               <= '0;
            state             <= pick(inst[3:1]);
            finished_decoding <= first_done;
            decoded_valid     <= first_done && ok;
        end else if (data_load && in_wait) begin
            if (state == WAIT_IMM) imm <= data;
            if (state == WAIT_DISP) disp <= data;
            if (state == WAIT_EXT) ext <= data;
            state             <= nxt;
            finished_decoding <= nxt == DONE;
            decoded_valid     <= nxt == DONE && ok;
        end
    end
endmodule

// File: tb/tb_ember_inst_decoder.sv
// tb_ember_inst_decoder: directed vector table plus random traffic against a queue-based reference model.
module tb_ember_inst_decoder;
    logic clk = 1'b0, rst = 1'b0, inst_load = 1'b0, data_load = 1'b0;
    logic [31:0] inst = '0;
    logic [63:0] data = '0;
    logic [11:0] opcode;
    logic [3:0] mode, flags;
    logic [5:0] rsrc, rdest;
    logic [63:0] imm, disp, ext;
    logic imm_present, disp_present, ext_present, finished_decoding, decoded_valid;

    int tests = 0, fails = 0;

`ifdef STRICT_MODE_CHECK_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif

    ember_inst_decoder dut (
        .clk(clk), .rst(rst), .inst_load(inst_load), .inst(inst),
        .data_load(data_load), .data(data), .opcode(opcode), .mode(mode),
        .rsrc(rsrc), .rdest(rdest), .flags(flags), .imm(imm), .disp(disp),
        .ext(ext), .imm_present(imm_present), .disp_present(disp_present),
        .ext_present(ext_present), .finished_decoding(finished_decoding),
        .decoded_valid(decoded_valid)
    );

    always #5 clk = ~clk;

    // Reference model: captured word plus a queue of still-missing extension slots
    bit          m_started;
    int          m_q[$];
    logic [31:0] m_inst;
    logic [63:0] m_w[3];

    function automatic bit m_legal();
        int md, rs, rd;
        bit l;
        md = int'(m_inst[19:16]);
        rs = int'(m_inst[15:10]);
        rd = int'(m_inst[9:4]);
        l = m_inst[0] && rs < 40 && rd < 40;
        if (STRICT)
            l = l && md >= 1 && md <= 4 && !(md == 3 && !m_inst[1]) && !(md == 4 && !m_inst[2]);
        return l;
    endfunction

    task automatic m_update(input bit r, input bit il, input logic [31:0] i, input bit dl, input logic [63:0] d);
        if (r) begin
            m_started = 0; m_q.delete(); m_inst = '0;
            for (int k = 0; k < 3; k++) m_w[k] = '0;
        end else if (il) begin
            m_started = 1; m_q.delete(); m_inst = i;
            for (int k = 0; k < 3; k++) begin
                m_w[k] = '0;
                if (i[k+1]) m_q.push_back(k);
            end
        end else if (dl && m_started && m_q.size() > 0) begin
            m_w[m_q.pop_front()] = d;
        end
    endtask

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    task automatic check_model();
        bit fin;
        fin = m_started && m_q.size() == 0;
        chk("opcode", 64'(opcode), 64'(m_inst[31:20]));
        chk("mode", 64'(mode), 64'(m_inst[19:16]));
        chk("rsrc", 64'(rsrc), 64'(m_inst[15:10]));
        chk("rdest", 64'(rdest), 64'(m_inst[9:4]));
        chk("flags", 64'(flags), 64'(m_inst[3:0]));
        chk("present", 64'({ext_present, disp_present, imm_present}), 64'(m_inst[3:1]));
        chk("imm", imm, m_w[0]);
        chk("disp", disp, m_w[1]);
        chk("ext", ext, m_w[2]);
        chk("finished", 64'(finished_decoding), 64'(fin));
        chk("valid", 64'(decoded_valid), 64'(fin && m_legal()));
    endtask

    task automatic cyc(input bit r, input bit il, input logic [31:0] i, input bit dl, input logic [63:0] d);
        rst = r; inst_load = il; inst = i; data_load = dl; data = d;
        @(posedge clk);
        m_update(r, il, i, dl, d);
        #1;
        check_model();
        rst = 0; inst_load = 0; data_load = 0;
    endtask

    typedef struct {
        bit il; logic [31:0] inst; bit dl; logic [63:0] data;
        bit fin; bit vld; logic [63:0] imm, disp, ext;
    } vec_t;

    vec_t v[$];

    function automatic vec_t mk(bit il, logic [31:0] i, bit dl, logic [63:0] d, bit f, bit vl,
                                logic [63:0] im, logic [63:0] di, logic [63:0] ex);
        vec_t t;
        t.il = il; t.inst = i; t.dl = dl; t.data = d; t.fin = f; t.vld = vl;
        t.imm = im; t.disp = di; t.ext = ex;
        return t;
    endfunction

    initial begin
        v.push_back(mk(0, 32'h0, 1, 64'hAB, 0, 0, 0, 0, 0));
        v.push_back(mk(1, 32'h11521051, 0, 0, 1, 1, 0, 0, 0));
        v.push_back(mk(1, 32'h11531053, 0, 0, 0, 0, 0, 0, 0));
        v.push_back(mk(0, 32'h0, 1, 64'hDEADBEEF_CAFEF00D, 1, 1, 64'hDEADBEEF_CAFEF00D, 0, 0));
        v.push_back(mk(1, 32'h1152105F, 0, 0, 0, 0, 0, 0, 0));
        v.push_back(mk(0, 32'h0, 1, 64'd1, 0, 0, 1, 0, 0));
        v.push_back(mk(0, 32'h0, 1, 64'd2, 0, 0, 1, 2, 0));
        v.push_back(mk(0, 32'h0, 1, 64'd3, 1, 1, 1, 2, 3));
        v.push_back(mk(0, 32'h0, 1, 64'd4, 1, 1, 1, 2, 3));
        v.push_back(mk(1, 32'h1152B451, 0, 0, 1, 0, 0, 0, 0));
        v.push_back(mk(1, 32'h11521050, 0, 0, 1, 0, 0, 0, 0));
        v.push_back(mk(1, 32'h11521053, 0, 0, 0, 0, 0, 0, 0));
        v.push_back(mk(1, 32'h11521051, 0, 0, 1, 1, 0, 0, 0));
        v.push_back(mk(0, 32'h0, 1, 64'h55, 1, 1, 0, 0, 0));
        v.push_back(mk(1, 32'h11521053, 0, 0, 0, 0, 0, 0, 0));
        v.push_back(mk(1, 32'h11521053, 1, 64'h77, 0, 0, 0, 0, 0));
        v.push_back(mk(0, 32'h0, 1, 64'h99, 1, 1, 64'h99, 0, 0));
        v.push_back(mk(1, 32'h11501051, 0, 0, 1, !STRICT, 0, 0, 0));
        v.push_back(mk(1, 32'h11531051, 0, 0, 1, !STRICT, 0, 0, 0));
        v.push_back(mk(1, 32'h11541051, 0, 0, 1, !STRICT, 0, 0, 0));
        v.push_back(mk(1, 32'h11551051, 0, 0, 1, !STRICT, 0, 0, 0));
        v.push_back(mk(1, 32'h11541055, 0, 0, 0, 0, 0, 0, 0));
        v.push_back(mk(0, 32'h0, 1, 64'h42, 1, 1, 0, 64'h42, 0));

        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("reset_fin", 64'(finished_decoding), 0);
        chk("reset_opcode", 64'(opcode), 0);

        for (int n = 0; n < v.size(); n++) begin
            cyc(0, v[n].il, v[n].inst, v[n].dl, v[n].data);
            chk($sformatf("vec%0d_fin", n), 64'(finished_decoding), 64'(v[n].fin));
            chk($sformatf("vec%0d_vld", n), 64'(decoded_valid), 64'(v[n].vld));
            chk($sformatf("vec%0d_imm", n), imm, v[n].imm);
            chk($sformatf("vec%0d_disp", n), disp, v[n].disp);
            chk($sformatf("vec%0d_ext", n), ext, v[n].ext);
        end
        chk("t1_opcode", 64'(opcode), 64'h115);

        for (int n = 0; n < 600; n++) begin
            logic [31:0] ri;
            ri = $urandom;
            if ($urandom_range(3) != 0) ri[15:10] = 6'($urandom_range(44));
            if ($urandom_range(3) != 0) ri[9:4] = 6'($urandom_range(44));
            if ($urandom_range(1) != 0) ri[19:16] = 4'($urandom_range(5));
            cyc(n == 300, $urandom_range(5) == 0, ri, $urandom_range(1) == 1,
                {$urandom, $urandom});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
